// File: rtl/regfile_scoreboard.sv
// Integer register file with N read / M write ports, optional write bypass,
// and a per-register busy scoreboard feeding hazard stalls to issue.
module regfile_scoreboard #(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int NWR    = 1,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      reg_wr,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic                issue_vld,
  input  logic [AW-1:0]       issue_rd,
  output logic                stall,
  output logic [AW:0]         busy_cnt
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  logic [XLEN-1:0] rf_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic [AW:0]     inc;
  logic [AW:0]     dec;

  logic [NREG-1:0] wen;
  logic [XLEN-1:0] wval [NREG];
  logic            set;

  // Ascending port order lets the highest-index writer win.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wen[r]  = 1'b0;
      wval[r] = '0;
    end
    for (int w = 0; w < NWR; w++) begin
      if (!reset && reg_wr[w] && waddr[w*AW +: AW] != '0) begin
        wen[waddr[w*AW +: AW]]  = 1'b1;
        wval[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
      end
    end
  end

  assign set = issue_vld && !reset && issue_rd != '0;

  // A new producer supersedes a retiring one, so set is applied last.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREG; r++) begin
      if (wen[r]) busy_d[r] = 1'b0;
    end
    if (set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NREG; r++) begin
      if (busy_d[r] && !busy_q[r]) inc = inc + CNT_ONE;
      if (!busy_d[r] && busy_q[r]) dec = dec + CNT_ONE;
    end
    cnt_d = cnt_q + inc - dec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wen[r]) rf_q[r] <= wval[r];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;
    assign ra  = raddr[i*AW +: AW];
    assign hit = (BYPASS != 0) && wen[ra];
    always_comb begin
      rdata[i*XLEN +: XLEN] = '0;
      rbusy[i]              = 1'b0;
      if (ra != '0) begin
        if (hit) begin
          rdata[i*XLEN +: XLEN] = wval[ra];
        end else begin
          rdata[i*XLEN +: XLEN] = rf_q[ra];
          rbusy[i]              = busy_q[ra];
        end
      end
    end
  end

  assign stall    = |rbusy;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: bypassing 2-write-port instance plus a
// non-bypass 1-write-port shadow driven from the same stimulus.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  raddr0 = '0;
  logic [63:0] rdata0;
  logic [1:0]  rbusy0;
  logic [1:0]  reg_wr0 = '0;
  logic [9:0]  waddr0 = '0;
  logic [63:0] wdata0 = '0;
  logic        issue_vld = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        stall0;
  logic [5:0]  cnt0;

  logic [63:0] rdata1;
  logic [1:0]  rbusy1;
  logic        stall1;
  logic [5:0]  cnt1;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NWR(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset),
    .raddr(raddr0), .rdata(rdata0), .rbusy(rbusy0),
    .reg_wr(reg_wr0), .waddr(waddr0), .wdata(wdata0),
    .issue_vld(issue_vld), .issue_rd(issue_rd),
    .stall(stall0), .busy_cnt(cnt0)
  );

  regfile_scoreboard #(.NWR(1), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset),
    .raddr(raddr0), .rdata(rdata1), .rbusy(rbusy1),
    .reg_wr(reg_wr0[0]), .waddr(waddr0[4:0]), .wdata(wdata0[31:0]),
    .issue_vld(issue_vld), .issue_rd(issue_rd),
    .stall(stall1), .busy_cnt(cnt1)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_wr0   = '0;
    issue_vld = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // writes and issues during reset must be ignored
    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd4}; wdata0 = {32'h0, 32'h11111111};
    issue_vld = 1'b1; issue_rd = 5'd4; raddr0 = {5'd0, 5'd4};
    tick(); tick();
    chk("rst_rdata", rdata0, 64'h0);
    chk("rst_rbusy", {62'h0, rbusy0}, 64'h0);
    chk("rst_stall", {63'h0, stall0}, 64'h0);
    chk("rst_cnt", {58'h0, cnt0}, 64'h0);
    idle();
    reset = 1'b0;
    tick();
    chk("rst_ignored_x4", rdata0[31:0], 64'h0);
    chk("rst_cnt_after", {58'h0, cnt0}, 64'h0);

    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd1}; wdata0 = {32'h0, 32'hDEADBEEF};
    tick();
    idle();
    raddr0 = {5'd0, 5'd1};
    #1;
    chk("wr_x1", rdata0[31:0], 64'hDEADBEEF);
    chk("wr_x1_busy", {63'h0, rbusy0[0]}, 64'h0);
    chk("wr_x1_nob", rdata1[31:0], 64'hDEADBEEF);

    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd2}; wdata0 = {32'h0, 32'hCAFEBABE};
    raddr0 = {5'd2, 5'd1};
    #1;
    chk("byp_x2", rdata0[63:32], 64'hCAFEBABE);
    chk("nob_x2_old", rdata1[63:32], 64'h0);
    tick();
    idle();
    #1;
    chk("nob_x2_new", rdata1[63:32], 64'hCAFEBABE);

    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd0}; wdata0 = {32'h0, 32'hFFFFFFFF};
    issue_vld = 1'b1; issue_rd = 5'd0; raddr0 = {5'd0, 5'd0};
    #1;
    chk("x0_byp", rdata0[31:0], 64'h0);
    tick();
    idle();
    #1;
    chk("x0_rdata", rdata0[31:0], 64'h0);
    chk("x0_rbusy", {63'h0, rbusy0[0]}, 64'h0);
    chk("x0_cnt", {58'h0, cnt0}, 64'h0);

    issue_vld = 1'b1; issue_rd = 5'd5;
    tick();
    idle();
    raddr0 = {5'd0, 5'd5};
    #1;
    chk("x5_rbusy", {63'h0, rbusy0[0]}, 64'h1);
    chk("x5_stall", {63'h0, stall0}, 64'h1);
    chk("x5_cnt", {58'h0, cnt0}, 64'h1);
    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd5}; wdata0 = {32'h0, 32'h12345678};
    #1;
    chk("x5_byp_data", rdata0[31:0], 64'h12345678);
    chk("x5_byp_rbusy", {63'h0, rbusy0[0]}, 64'h0);
    chk("x5_nob_rbusy", {63'h0, rbusy1[0]}, 64'h1);
    chk("x5_nob_old", rdata1[31:0], 64'h0);
    tick();
    idle();
    #1;
    chk("x5_clr_cnt", {58'h0, cnt0}, 64'h0);
    chk("x5_data", rdata0[31:0], 64'h12345678);
    chk("x5_nob_data", rdata1[31:0], 64'h12345678);
    chk("x5_nob_free", {63'h0, rbusy1[0]}, 64'h0);

    issue_vld = 1'b1; issue_rd = 5'd7;
    tick();
    chk("x7_cnt1", {58'h0, cnt0}, 64'h1);
    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd7}; wdata0 = {32'h0, 32'h00000077};
    tick();
    idle();
    raddr0 = {5'd0, 5'd7};
    #1;
    chk("x7_set_wins_cnt", {58'h0, cnt0}, 64'h1);
    chk("x7_still_busy", {63'h0, rbusy0[0]}, 64'h1);
    chk("x7_nob_busy", {63'h0, rbusy1[0]}, 64'h1);
    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd7}; wdata0 = {32'h0, 32'h00000078};
    tick();
    idle();
    #1;
    chk("x7_cleared", {58'h0, cnt0}, 64'h0);
    chk("x7_data", rdata0[31:0], 64'h78);

    reg_wr0 = 2'b01; waddr0 = {5'd0, 5'd9}; wdata0 = {32'h0, 32'h9};
    tick();
    idle();
    chk("clr_idle_cnt", {58'h0, cnt0}, 64'h0);

    reg_wr0 = 2'b11; waddr0 = {5'd3, 5'd3};
    wdata0 = {32'h5555FFFF, 32'hAAAA0000};
    raddr0 = {5'd0, 5'd3};
    #1;
    chk("x3_byp_prio", rdata0[31:0], 64'h5555FFFF);
    tick();
    idle();
    #1;
    chk("x3_stored", rdata0[31:0], 64'h5555FFFF);

    for (int r = 1; r < 32; r++) begin
      issue_vld = 1'b1;
      issue_rd  = 5'(r);
      tick();
      if (r == 16) chk("fill_cnt16", {58'h0, cnt0}, 64'd16);
    end
    chk("fill_cnt31", {58'h0, cnt0}, 64'd31);
    chk("fill_nob31", {58'h0, cnt1}, 64'd31);
    issue_rd = 5'd5;
    tick();
    idle();
    raddr0 = {5'd3, 5'd1};
    #1;
    chk("rebusy_cnt31", {58'h0, cnt0}, 64'd31);
    chk("full_rbusy", {62'h0, rbusy0}, 64'h3);
    chk("full_x1", rdata0[31:0], 64'hDEADBEEF);

    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cnt", {58'h0, cnt0}, 64'h0);
    chk("mid_rst_rbusy", {62'h0, rbusy0}, 64'h0);
    chk("mid_rst_rdata", rdata0, 64'h0);
    chk("mid_rst_stall", {63'h0, stall0}, 64'h0);
    chk("mid_rst_nob", {58'h0, cnt1}, 64'h0);
    chk("mid_rst_nob_rd", rdata1, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
